// File: rtl/imem_boot_loader_if.sv
// Byte-stream handshake feeding the instruction-memory boot loader.
// The producer (UART receiver, debug bridge, bench) takes the master side;
// the loader takes the slave side and answers with rx_ready.
interface imem_boot_loader_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready
    );
endinterface

// File: rtl/imem_boot_loader.sv
// Instruction-memory boot loader for the RV32I core.
// Takes a byte stream (LEN_L, LEN_H, then 4*N little-endian data bytes),
// packs it into 32-bit words, writes them into instruction memory and keeps
// the core in reset until the image is complete. A reload pulse while running
// (or after a failed load) restarts the whole sequence.
// Optional feature: define IMEM_CSUM_EN to require one trailing checksum byte
// (XOR of all data bytes) before the core is released.
module imem_boot_loader #(
    parameter int DEPTH_W = 8
) (
    input  logic                clk,
    input  logic                rst,
    imem_boot_loader_if.slave   rx,
    input  logic                reload,
    output logic                imem_we,
    output logic [31:0]         imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                core_rst,
    output logic                done,
    output logic                err
);

`ifdef IMEM_CSUM_EN
    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_CSUM,
        S_RUN,
        S_ERR
    } state_t;
    localparam state_t S_AFTER_DATA = S_CSUM;
`else
    typedef enum logic [2:0] {
        S_HDR0,
        S_HDR1,
        S_DATA,
        S_RUN,
        S_ERR
    } state_t;
    localparam state_t S_AFTER_DATA = S_RUN;
`endif

    localparam logic [16:0]      MAX_WORDS = 17'd1 << DEPTH_W;
    localparam logic [DEPTH_W:0] IDX_ONE   = {{DEPTH_W{1'b0}}, 1'b1};

    state_t             state;
    state_t             next_state;

    logic               accept;
    logic [7:0]         len_l;
    logic [15:0]        hdr_len;
    logic               hdr_too_long;
    logic [1:0]         byte_cnt;
    logic [DEPTH_W:0]   word_idx;
    logic [DEPTH_W:0]   word_total;
    logic [23:0]        word_buf;
    logic               last_lane;
    logic               last_word;
    logic               running;
    logic               load_next;
`ifdef IMEM_CSUM_EN
    logic [7:0]         csum_acc;
`endif

    assign accept       = rx.rx_valid & rx.rx_ready;
    assign hdr_len      = {rx.rx_data, len_l};
    assign hdr_too_long = {1'b0, hdr_len} > MAX_WORDS;
    assign last_lane    = (byte_cnt == 2'd3);
    assign last_word    = ((word_idx + IDX_ONE) == word_total);

    // The core is only released once the FSM has already spent one cycle in
    // RUN, so the final write strobe and core_rst falling never overlap.
    assign running   = (state == S_RUN) && (next_state == S_RUN);
    assign load_next = (next_state != S_RUN) && (next_state != S_ERR);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_HDR0;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: header parsing, data counting and reload handling.
    always_comb begin
        next_state = state;
        case (state)
            S_HDR0: begin
                if (accept) begin
                    next_state = S_HDR1;
                end
            end
            S_HDR1: begin
                if (accept) begin
                    if (hdr_len == 16'd0) begin
                        next_state = S_AFTER_DATA;
                    end else if (hdr_too_long) begin
                        next_state = S_ERR;
                    end else begin
                        next_state = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (accept && last_lane && last_word) begin
                    next_state = S_AFTER_DATA;
                end
            end
`ifdef IMEM_CSUM_EN
            S_CSUM: begin
                if (accept) begin
                    next_state = (rx.rx_data == csum_acc) ? S_RUN : S_ERR;
                end
            end
`endif
            S_RUN: begin
                if (reload) begin
                    next_state = S_HDR0;
                end
            end
            S_ERR: begin
                if (reload) begin
                    next_state = S_HDR0;
                end
            end
            default: begin
                next_state = S_HDR0;
            end
        endcase
    end

    // Registered status outputs derived from where the FSM is heading, so
    // rx_ready drops on the same edge that accepts the final byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx.rx_ready <= 1'b1;
            core_rst    <= 1'b1;
            done        <= 1'b0;
            err         <= 1'b0;
        end else begin
            rx.rx_ready <= load_next;
            core_rst    <= !running;
            done        <= running;
            err         <= (next_state == S_ERR);
        end
    end

    // Datapath: length capture, lane packing, word write strobe and counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_l      <= 8'd0;
            byte_cnt   <= 2'd0;
            word_idx   <= '0;
            word_total <= '0;
            word_buf   <= 24'd0;
            imem_we    <= 1'b0;
            imem_addr  <= 32'd0;
            imem_wdata <= 32'd0;
`ifdef IMEM_CSUM_EN
            csum_acc   <= 8'd0;
`endif
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_HDR0: begin
                    if (accept) begin
                        len_l <= rx.rx_data;
                    end
                end
                S_HDR1: begin
                    if (accept) begin
                        word_total <= hdr_len[DEPTH_W:0];
                        word_idx   <= '0;
                        byte_cnt   <= 2'd0;
`ifdef IMEM_CSUM_EN
                        csum_acc   <= 8'd0;
`endif
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_CSUM_EN
                        csum_acc <= csum_acc ^ rx.rx_data;
`endif
                        case (byte_cnt)
                            2'd0: word_buf[7:0]   <= rx.rx_data;
                            2'd1: word_buf[15:8]  <= rx.rx_data;
                            2'd2: word_buf[23:16] <= rx.rx_data;
                            default: begin
                                imem_we    <= 1'b1;
                                imem_wdata <= {rx.rx_data, word_buf};
                                imem_addr  <= {{(29 - DEPTH_W){1'b0}}, word_idx, 2'b00};
                                word_idx   <= word_idx + IDX_ONE;
                            end
                        endcase
                    end
                end
                S_RUN, S_ERR: begin
                    if (reload) begin
                        byte_cnt   <= 2'd0;
                        word_idx   <= '0;
                        word_total <= '0;
`ifdef IMEM_CSUM_EN
                        csum_acc   <= 8'd0;
`endif
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_boot_loader.sv
// Self-checking bench for imem_boot_loader: directed scenarios plus
// randomized images, compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_imem_boot_loader;

    localparam int DEPTH_W   = 8;
    localparam int MAX_WORDS = 1 << DEPTH_W;

    localparam int M_HDR0 = 0;
    localparam int M_HDR1 = 1;
    localparam int M_DATA = 2;
    localparam int M_CSUM = 3;
    localparam int M_RUN  = 4;
    localparam int M_ERR  = 5;
`ifdef IMEM_CSUM_EN
    localparam int M_AFTER = M_CSUM;
`else
    localparam int M_AFTER = M_RUN;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        reload = 1'b0;
    logic        imem_we;
    logic [31:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        core_rst;
    logic        done;
    logic        err;

    imem_boot_loader_if bus();

    imem_boot_loader #(.DEPTH_W(DEPTH_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .rx         (bus),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int          m_state = M_HDR0;
    int          m_prev  = M_HDR0;
    int          m_n     = 0;
    int          m_widx  = 0;
    logic [7:0]  m_len_l = 8'd0;
    logic [7:0]  m_csum  = 8'd0;
    logic [7:0]  m_bytes[$];
    logic        m_ready    = 1'b1;
    logic        m_we       = 1'b0;
    logic [31:0] m_addr     = 32'd0;
    logic [31:0] m_wdata    = 32'd0;
    logic        m_core_rst = 1'b1;
    logic        m_done     = 1'b0;
    logic        m_err      = 1'b0;
    bit          last_acc   = 1'b0;

    // Observations of the DUT write port for directed literal checks
    int          strobe_count = 0;
    logic [31:0] seen_addr    = 32'd0;
    logic [31:0] seen_wdata   = 32'd0;

    // Stimulus knobs
    int          gap_max      = 0;
    bit          noise_reload = 1'b0;
    logic [31:0] img_words[$];

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                     name, actual, expected, $time);
        end
    endtask

    // Model: the loader as a byte-stream parser; outputs follow from the
    // parse position after each edge.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state    = M_HDR0;
            m_prev     = M_HDR0;
            m_n        = 0;
            m_widx     = 0;
            m_csum     = 8'd0;
            m_bytes.delete();
            m_ready    = 1'b1;
            m_we       = 1'b0;
            m_addr     = 32'd0;
            m_wdata    = 32'd0;
            m_core_rst = 1'b1;
            m_done     = 1'b0;
            m_err      = 1'b0;
            last_acc   = 1'b0;
        end else begin
            m_prev   = m_state;
            last_acc = bus.rx_valid && m_ready;
            m_we     = 1'b0;
            if (reload && (m_state == M_RUN || m_state == M_ERR)) begin
                m_state = M_HDR0;
                m_widx  = 0;
                m_bytes.delete();
            end else if (last_acc) begin
                case (m_state)
                    M_HDR0: begin
                        m_len_l = bus.rx_data;
                        m_state = M_HDR1;
                    end
                    M_HDR1: begin
                        m_n    = int'({bus.rx_data, m_len_l});
                        m_widx = 0;
                        m_csum = 8'd0;
                        m_bytes.delete();
                        if (m_n == 0)              m_state = M_AFTER;
                        else if (m_n > MAX_WORDS)  m_state = M_ERR;
                        else                       m_state = M_DATA;
                    end
                    M_DATA: begin
                        m_bytes.push_back(bus.rx_data);
                        m_csum = m_csum ^ bus.rx_data;
                        if (m_bytes.size() == 4) begin
                            m_wdata = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                            m_addr  = 32'(m_widx * 4);
                            m_we    = 1'b1;
                            m_widx++;
                            m_bytes.delete();
                            if (m_widx == m_n) m_state = M_AFTER;
                        end
                    end
                    M_CSUM: begin
                        m_state = (bus.rx_data == m_csum) ? M_RUN : M_ERR;
                    end
                    default: begin
                    end
                endcase
            end
            m_ready    = (m_state != M_RUN) && (m_state != M_ERR);
            m_err      = (m_state == M_ERR);
            m_done     = (m_prev == M_RUN) && (m_state == M_RUN);
            m_core_rst = !m_done;
        end
    end

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        check_output("rx_ready",   {31'd0, bus.rx_ready}, {31'd0, m_ready});
        check_output("imem_we",    {31'd0, imem_we},      {31'd0, m_we});
        check_output("imem_addr",  imem_addr,             m_addr);
        check_output("imem_wdata", imem_wdata,            m_wdata);
        check_output("core_rst",   {31'd0, core_rst},     {31'd0, m_core_rst});
        check_output("done",       {31'd0, done},         {31'd0, m_done});
        check_output("err",        {31'd0, err},          {31'd0, m_err});
        if (imem_we === 1'b1) begin
            strobe_count++;
            seen_addr  = imem_addr;
            seen_wdata = imem_wdata;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic reload_pulse();
        reload = 1'b1;
        @(posedge clk);
        #1;
        reload = 1'b0;
    endtask

    // Offer one byte, optionally after random idle gaps (with ignored reload
    // noise), and hold it until the loader takes it.
    task automatic send_byte(input logic [7:0] b);
        int waited;
        int gaps;
        gaps = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (gaps) begin
            bus.rx_valid = 1'b0;
            bus.rx_data  = 8'($urandom);
            reload       = noise_reload && ($urandom_range(3, 0) == 0);
            @(posedge clk);
            #1;
        end
        reload       = 1'b0;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        waited = 0;
        do begin
            @(posedge clk);
            #1;
            waited++;
        end while (!last_acc && waited < 50);
        bus.rx_valid = 1'b0;
        if (!last_acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL send_byte timeout: got no accept, expected accept of 0x%02h", b);
        end
    endtask

    // Header, img_words payload and (when enabled) the correct checksum.
    task automatic apply_stimulus(input int n);
        logic [15:0] len;
        logic [7:0]  x;
        logic [31:0] w;
        len = 16'(n);
        x   = 8'd0;
        send_byte(len[7:0]);
        send_byte(len[15:8]);
        if (n <= MAX_WORDS) begin
            for (int i = 0; i < n; i++) begin
                w = img_words[i];
                for (int j = 0; j < 4; j++) begin
                    x = x ^ w[8*j +: 8];
                    send_byte(w[8*j +: 8]);
                end
            end
`ifdef IMEM_CSUM_EN
            send_byte(x);
`endif
        end
    endtask

    task automatic fill_words(input int n);
        img_words.delete();
        for (int i = 0; i < n; i++) img_words.push_back($urandom);
    endtask

    initial begin
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'd0;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_core_rst", {31'd0, core_rst},     32'd1);
        check_output("reset_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        rst = 1'b1;

        // Single instruction word
        strobe_count = 0;
        img_words.delete();
        img_words.push_back(32'h00A00513);
        apply_stimulus(1);
        idle(3);
        check_output("t1_strobes",  32'(strobe_count), 32'd1);
        check_output("t1_addr",     seen_addr,         32'h0);
        check_output("t1_wdata",    seen_wdata,        32'h00A00513);
        check_output("t1_done",     {31'd0, done},     32'd1);
        check_output("t1_core_rst", {31'd0, core_rst}, 32'd0);
        check_output("t1_rx_ready", {31'd0, bus.rx_ready}, 32'd0);

        // Three words back-to-back
        reload_pulse();
        strobe_count = 0;
        img_words.delete();
        img_words.push_back(32'h11111111);
        img_words.push_back(32'h22222222);
        img_words.push_back(32'h33333333);
        apply_stimulus(3);
        idle(3);
        check_output("t2_strobes", 32'(strobe_count), 32'd3);
        check_output("t2_addr",    seen_addr,         32'h8);
        check_output("t2_wdata",   seen_wdata,        32'h33333333);

        // Oversized image
        reload_pulse();
        strobe_count = 0;
        send_byte(8'h01);
        send_byte(8'h01);
        idle(3);
        check_output("t3_err",      {31'd0, err},      32'd1);
        check_output("t3_core_rst", {31'd0, core_rst}, 32'd1);
        check_output("t3_strobes",  32'(strobe_count), 32'd0);
        reload_pulse();
        check_output("t3_reload_err",   {31'd0, err},          32'd0);
        check_output("t3_reload_ready", {31'd0, bus.rx_ready}, 32'd1);

        // Empty image
        strobe_count = 0;
        send_byte(8'h00);
        send_byte(8'h00);
`ifdef IMEM_CSUM_EN
        send_byte(8'h00);
`endif
        check_output("t4_done_early", {31'd0, done}, 32'd0);
        idle(1);
        check_output("t4_done",    {31'd0, done},     32'd1);
        check_output("t4_strobes", 32'(strobe_count), 32'd0);

        // Reset in the middle of a load
        reload_pulse();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'hAA);
        send_byte(8'hBB);
        rst = 1'b0;
        #2;
        check_output("t5_core_rst", {31'd0, core_rst},     32'd1);
        check_output("t5_rx_ready", {31'd0, bus.rx_ready}, 32'd1);
        check_output("t5_addr",     imem_addr,             32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        strobe_count = 0;
        img_words.delete();
        img_words.push_back(32'hDEADBEEF);
        apply_stimulus(1);
        idle(3);
        check_output("t5_strobes", 32'(strobe_count), 32'd1);
        check_output("t5_wdata",   seen_wdata,        32'hDEADBEEF);
        check_output("t5_done",    {31'd0, done},     32'd1);

`ifdef IMEM_CSUM_EN
        // Checksum accept / reject
        reload_pulse();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h04);
        idle(3);
        check_output("t6_done", {31'd0, done}, 32'd1);
        reload_pulse();
        send_byte(8'h01); send_byte(8'h00);
        send_byte(8'h04); send_byte(8'h03); send_byte(8'h02); send_byte(8'h01);
        send_byte(8'h05);
        idle(3);
        check_output("t6_err", {31'd0, err}, 32'd1);
`endif

        // Randomized images with gaps and ignored reload noise
        noise_reload = 1'b1;
        for (int iter = 0; iter < 14; iter++) begin
            int n;
            case (iter)
                0:       n = MAX_WORDS;
                1:       n = 0;
                2:       n = MAX_WORDS + 1 + int'($urandom_range(2000, 0));
                default: n = int'($urandom_range(12, 1));
            endcase
            gap_max = (iter == 0) ? 0 : int'($urandom_range(3, 0));
            reload_pulse();
            strobe_count = 0;
            fill_words((n <= MAX_WORDS) ? n : 0);
            apply_stimulus(n);
            idle(3);
            check_output("rnd_strobes", 32'(strobe_count),
                         (n <= MAX_WORDS) ? 32'(n) : 32'd0);
            check_output("rnd_done", {31'd0, done},
                         (n <= MAX_WORDS) ? 32'd1 : 32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got no completion, expected finish before %0t", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
